// File: rtl/envelope_adsr.sv
// ADSR amplitude envelope: tick-paced level FSM scaling a midscale-256 sample.
// Latency: outputs register on the mclk edge that ends a tick cycle and hold between ticks.
// Backpressure: none; the block advances only on tick and never stalls upstream.
module envelope_adsr #(
  parameter int unsigned ATTACK_STEP   = 32,
  parameter int unsigned DECAY_STEP    = 8,
  parameter int unsigned SUSTAIN_LEVEL = 192,
  parameter int unsigned RELEASE_STEP  = 4
) (
  input  logic       mclk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       gate,
  input  logic [4:0] note,
  input  logic [8:0] sample_in,
  output logic [8:0] sample_out,
  output logic [7:0] env_level,
  output logic       active
);

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  state_t     state_q, state_d, state_eff;
  logic [7:0] level_q, level_d;
  logic       gate_q, gate_d;
  logic [4:0] note_q, note_d;
  logic [8:0] sample_out_q, sample_out_d;

  logic       gate_rise, gate_fall, note_chg;
  logic [8:0] att_sum;
  logic signed [17:0] diff_s, lvl_s, prod_s, scaled_s;

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    gate_d    = gate_q;
    note_d    = note_q;
    state_eff = state_q;
    gate_rise = gate & ~gate_q;
    gate_fall = ~gate & gate_q;
    note_chg  = gate & gate_q & (note != note_q);
    att_sum   = {1'b0, level_q} + 9'(ATTACK_STEP);

    if (tick) begin
      gate_d = gate;
      note_d = note;
      // Trigger/release decide the state first; the step for that state applies on the same tick.
      if (gate_rise || note_chg) begin
        state_eff = ATTACK;
      end else if (gate_fall && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
        state_eff = RELEASE;
      end
      state_d = state_eff;

      case (state_eff)
        IDLE: level_d = '0;
        ATTACK: begin
          if (att_sum >= 9'd255) begin
            level_d = 8'd255;
            state_d = DECAY;
          end else begin
            level_d = att_sum[7:0];
          end
        end
        DECAY: begin
          if ({1'b0, level_q} <= 9'(SUSTAIN_LEVEL + DECAY_STEP)) begin
            level_d = 8'(SUSTAIN_LEVEL);
            state_d = SUSTAIN;
          end else begin
            level_d = level_q - 8'(DECAY_STEP);
          end
        end
        SUSTAIN: level_d = level_q;
        RELEASE: begin
          if (level_q <= 8'(RELEASE_STEP)) begin
            level_d = '0;
            state_d = IDLE;
          end else begin
            level_d = level_q - 8'(RELEASE_STEP);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Signed scaling around midscale with the level being written this tick.
  always_comb begin
    diff_s       = signed'(18'(sample_in)) - 18'sd256;
    lvl_s        = signed'(18'(level_d));
    prod_s       = diff_s * lvl_s;
    scaled_s     = prod_s >>> 8;
    sample_out_d = tick ? 9'(scaled_s + 18'sd256) : sample_out_q;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      level_q      <= '0;
      gate_q       <= 1'b0;
      note_q       <= '0;
      sample_out_q <= 9'd256;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      gate_q       <= gate_d;
      note_q       <= note_d;
      sample_out_q <= sample_out_d;
    end
  end

  assign sample_out = sample_out_q;
  assign env_level  = level_q;
  assign active     = (state_q != IDLE);

endmodule

// File: tb/tb_envelope_adsr.sv
// Bench for envelope_adsr: tick-level model feeds a scoreboard, plus fixed-value checkpoints.
module tb_envelope_adsr;

  localparam int A_STEP = 32;
  localparam int D_STEP = 8;
  localparam int S_LVL  = 192;
  localparam int R_STEP = 4;

  logic       mclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       gate = 1'b0;
  logic [4:0] note = '0;
  logic [8:0] sample_in = 9'd256;
  logic [8:0] sample_out;
  logic [7:0] env_level;
  logic       active;

  envelope_adsr dut (
    .mclk      (mclk),
    .reset_n   (reset_n),
    .tick      (tick),
    .gate      (gate),
    .note      (note),
    .sample_in (sample_in),
    .sample_out(sample_out),
    .env_level (env_level),
    .active    (active)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [7:0] lvl;
    logic       act;
    logic [8:0] out;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
  int m_state, m_level, m_gq, m_nq, m_out;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_level = 0; m_gq = 0; m_nq = 0; m_out = 256;
  endtask

  task automatic model_step(input int g, input int n, input int s);
    int p, q;
    if ((g == 1 && m_gq == 0) || (g == 1 && m_gq == 1 && n != m_nq)) m_state = 1;
    else if (g == 0 && m_gq == 1 && m_state >= 1 && m_state <= 3) m_state = 4;
    case (m_state)
      1: begin m_level += A_STEP; if (m_level >= 255) begin m_level = 255; m_state = 2; end end
      2: begin m_level -= D_STEP; if (m_level <= S_LVL) begin m_level = S_LVL; m_state = 3; end end
      4: begin m_level -= R_STEP; if (m_level <= 0) begin m_level = 0; m_state = 0; end end
      3: ;
      default: m_level = 0;
    endcase
    p = (s - 256) * m_level;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    m_out = 256 + q;
    m_gq = g;
    m_nq = n;
  endtask

  // One tick with scoreboard check, then one idle cycle with scrambled inputs that must change nothing.
  task automatic do_tick(input int g, input int n, input int s);
    exp_t e;
    tick = 1'b1; gate = g[0]; note = n[4:0]; sample_in = s[8:0];
    model_step(g, n, s);
    e.lvl = m_level[7:0];
    e.act = (m_state != 0);
    e.out = m_out[8:0];
    sb_q.push_back(e);
    @(posedge mclk); #1;
    tick = 1'b0;
    e = sb_q.pop_front();
    check_val("sb_level", env_level, e.lvl);
    check_val("sb_active", active, e.act);
    check_val("sb_out", sample_out, e.out);
    gate = 1'($urandom); note = 5'($urandom); sample_in = 9'($urandom);
    @(posedge mclk); #1;
    check_val("hold_level", env_level, e.lvl);
    check_val("hold_out", sample_out, e.out);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check_val("rst_level", env_level, 0);
    check_val("rst_active", active, 0);
    check_val("rst_out", sample_out, 256);
    @(posedge mclk); #1;
    reset_n = 1'b1;

    // Attack from reset with gate already high
    for (int i = 1; i <= 8; i++) begin
      do_tick(1, 3, (i == 8) ? 511 : int'($urandom_range(0, 511)));
      check_val("att_level", env_level, (i == 8) ? 255 : 32 * i);
      check_val("att_active", active, 1);
    end
    check_val("att_full_out", sample_out, 510);

    // Decay down to sustain, then hold
    for (int i = 1; i <= 8; i++) begin
      do_tick(1, 3, $urandom_range(0, 511));
      check_val("dec_level", env_level, (i == 8) ? 192 : 255 - 8 * i);
    end
    for (int i = 0; i < 20; i++) begin
      do_tick(1, 3, $urandom_range(0, 511));
      check_val("sus_level", env_level, 192);
    end

    // Release to idle
    for (int i = 1; i <= 48; i++) begin
      do_tick(0, 3, $urandom_range(0, 511));
      check_val("rel_level", env_level, 192 - 4 * i);
      if (i < 48) check_val("rel_active", active, 1);
    end
    check_val("idle_active", active, 0);
    check_val("idle_out", sample_out, 256);

    // Re-attack, decay, sustain; then note-change retrigger from 192
    for (int i = 0; i < 20; i++) do_tick(1, 1, $urandom_range(0, 511));
    check_val("sus2_level", env_level, 192);
    do_tick(1, 2, $urandom_range(0, 511));
    check_val("retrig_level", env_level, 224);
    do_tick(1, 2, 0);
    check_val("retrig_full", env_level, 255);
    check_val("full_zero_out", sample_out, 1);
    for (int i = 0; i < 10; i++) do_tick(1, 2, $urandom_range(0, 511));
    check_val("sus3_level", env_level, 192);

    // Gate fall together with note change: release wins
    do_tick(0, 9, $urandom_range(0, 511));
    check_val("fall_prio", env_level, 188);
    for (int i = 2; i <= 16; i++) do_tick(0, 9, (i == 16) ? 0 : int'($urandom_range(0, 511)));
    check_val("half_level", env_level, 128);
    check_val("half_zero_out", sample_out, 128);
    for (int i = 0; i < 32; i++) do_tick(0, 9, $urandom_range(0, 511));
    check_val("idle2_active", active, 0);

    // Async reset during attack at level 96
    for (int i = 0; i < 3; i++) do_tick(1, 4, $urandom_range(0, 511));
    check_val("pre_rst_level", env_level, 96);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_val("mid_rst_level", env_level, 0);
    check_val("mid_rst_active", active, 0);
    check_val("mid_rst_out", sample_out, 256);
    @(posedge mclk); #1;
    reset_n = 1'b1;
    do_tick(1, 4, $urandom_range(0, 511));
    check_val("post_rst_level", env_level, 32);

    // Random gate/note traffic against the model
    for (int i = 0; i < 300; i++) begin
      do_tick(($urandom_range(0, 9) < 7) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 511));
    end

    check_val("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
